// File: rtl/cache_lock_pkg.sv
// rtl/cache_lock_pkg.sv - shared types and helpers for the cache lock arbiter
//
// Purpose: FSM state encoding, lock lookup classification, the lock table
// entry layout and the line-tag extraction helper. No ports.
// Optional feature macro used by importers: CACHE_LOCK_TIMEOUT_EN.

package cache_lock_pkg;

  // Tags, owners and ages are stored at fixed maximum widths so the entry
  // struct can live in the package; unused upper tag bits are always zero.
  localparam int TAG_MAX_W = 32;
  localparam int OWNER_W   = 4;   // enough for 16 ports
  localparam int AGE_MAX_W = 16;  // covers LOCK_TIMEOUT up to 65535

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    MISS,
    OWN_HIT,
    FOREIGN_HIT
  } lookup_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [OWNER_W-1:0]   owner;
    logic [AGE_MAX_W-1:0] age;
  } lock_entry_t;

  function automatic logic [TAG_MAX_W-1:0] line_tag(input logic [63:0] addr,
                                                    input int          off_w);
    return TAG_MAX_W'(addr >> off_w);
  endfunction

endpackage

// File: rtl/cache_lock_table.sv
// rtl/cache_lock_table.sv - line lock table with owner tracking
//
// Purpose: holds LOCK_ENTRIES line locks. Lookup is combinational; the
// allocate/refresh/release update is applied at the clock edge using the
// same lookup result. With CACHE_LOCK_TIMEOUT_EN each valid entry ages and
// is dropped after LOCK_TIMEOUT cycles.
// Ports:
//   clock, reset         rising-edge clock, async active-low reset
//   lookup_tag/owner     line tag and requesting port to classify
//   lookup_result        MISS / OWN_HIT / FOREIGN_HIT
//   full                 no free entry
//   update_en            apply an update for the looked-up tag/owner
//   update_lock          1: allocate or refresh, 0: release

module cache_lock_table
  import cache_lock_pkg::*;
#(
  parameter int LOCK_ENTRIES = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [TAG_MAX_W-1:0] lookup_tag,
  input  logic [OWNER_W-1:0]   lookup_owner,
  output lookup_e              lookup_result,
  output logic                 full,
  input  logic                 update_en,
  input  logic                 update_lock
);

  localparam int IDX_W = (LOCK_ENTRIES > 1) ? $clog2(LOCK_ENTRIES) : 1;

  lock_entry_t      entries [LOCK_ENTRIES];
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             do_alloc;
  logic             do_refresh;
  logic             do_release;

  // Allocation only happens on a miss, so at most one entry matches a tag.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < LOCK_ENTRIES; i++) begin
      if (!hit && entries[i].valid && entries[i].tag == lookup_tag) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!free_found && !entries[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign full = ~free_found;

  always_comb begin
    lookup_result = MISS;
    if (hit) begin
      lookup_result = (entries[hit_idx].owner == lookup_owner) ? OWN_HIT : FOREIGN_HIT;
    end
  end

  assign do_alloc   = update_en &&  update_lock && !hit && free_found;
  assign do_refresh = update_en &&  update_lock && (lookup_result == OWN_HIT);
  assign do_release = update_en && !update_lock && (lookup_result == OWN_HIT);

  // Explicit updates are checked first so they win over expiry in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LOCK_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LOCK_ENTRIES; i++) begin
        if (do_alloc && free_idx == IDX_W'(i)) begin
          entries[i].valid <= 1'b1;
          entries[i].tag   <= lookup_tag;
          entries[i].owner <= lookup_owner;
          entries[i].age   <= '0;
        end else if (do_refresh && hit_idx == IDX_W'(i)) begin
          entries[i].age <= '0;
        end else if (do_release && hit_idx == IDX_W'(i)) begin
          entries[i].valid <= 1'b0;
        end
`ifdef CACHE_LOCK_TIMEOUT_EN
        else if (entries[i].valid) begin
          if (entries[i].age >= AGE_MAX_W'(LOCK_TIMEOUT)) begin
            entries[i].valid <= 1'b0;
          end else begin
            entries[i].age <= entries[i].age + 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: rtl/cache_lock_arbiter.sv
// rtl/cache_lock_arbiter.sv - round-robin multi-port front end with line locks
//
// Purpose: grants one client port at a time (round-robin), rejects accesses
// to lines locked by another port, forwards the rest to the single cache
// channel and maintains lock ownership from successful cache responses.
// Optional feature macro: CACHE_LOCK_TIMEOUT_EN (lock auto-release).
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   req_valid/ready/addr/data/mask/lock   per-port request channel (packed)
//   rsp_valid/ready              per-port response handshake
//   rsp_data, rsp_success        shared response payload
//   cache_req_*                  request channel to the cache core
//   cache_rsp_*                  response channel from the cache core

module cache_lock_arbiter
  import cache_lock_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 512,
  parameter int MASK_W       = DATA_W / 8,
  parameter int OFF_W        = 6,
  parameter int LOCK_ENTRIES = 8,
  parameter int PORT_W       = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data,
  input  logic [NUM_PORTS*MASK_W-1:0] req_mask,
  input  logic [NUM_PORTS-1:0]        req_lock,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  input  logic [NUM_PORTS-1:0]        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_success,
  output logic                        cache_req_valid,
  input  logic                        cache_req_ready,
  output logic [ADDR_W-1:0]           cache_req_addr,
  output logic [DATA_W-1:0]           cache_req_data,
  output logic [MASK_W-1:0]           cache_req_mask,
  output logic [PORT_W-1:0]           cache_req_port,
  input  logic                        cache_rsp_valid,
  output logic                        cache_rsp_ready,
  input  logic [DATA_W-1:0]           cache_rsp_data,
  input  logic                        cache_rsp_success
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  state_e               state;
  state_e               state_next;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_found;
  logic                 grant_reject;
  int                   rr_p;
  logic [ADDR_W-1:0]    grant_addr;
  logic [IDX_W-1:0]     cur_port;
  logic [ADDR_W-1:0]    cur_addr;
  logic [DATA_W-1:0]    cur_data;
  logic [MASK_W-1:0]    cur_mask;
  logic                 cur_lock;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 rsp_success_q;
  logic [TAG_MAX_W-1:0] lookup_tag;
  logic [OWNER_W-1:0]   lookup_owner;
  lookup_e              lookup_result;
  logic                 table_full;
  logic                 update_en;

  // First valid port after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_p        = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_p = int'(last_grant) + k;
      if (rr_p >= NUM_PORTS) begin
        rr_p = rr_p - NUM_PORTS;
      end
      if (!grant_found && req_valid[rr_p]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(rr_p);
      end
    end
  end

  assign grant_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];

  // IDLE classifies the incoming grant; later states re-look-up the held
  // request so the update acts on the table as it is at response time.
  assign lookup_tag   = line_tag(64'((state == IDLE) ? grant_addr : cur_addr), OFF_W);
  assign lookup_owner = OWNER_W'((state == IDLE) ? grant_idx : cur_port);

  assign grant_reject = (lookup_result == FOREIGN_HIT) ||
                        (req_lock[grant_idx] && (lookup_result == MISS) && table_full);

  cache_lock_table #(
    .LOCK_ENTRIES (LOCK_ENTRIES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_table (
    .clock         (clock),
    .reset         (reset),
    .lookup_tag    (lookup_tag),
    .lookup_owner  (lookup_owner),
    .lookup_result (lookup_result),
    .full          (table_full),
    .update_en     (update_en),
    .update_lock   (cur_lock)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    req_ready       = '0;
    rsp_valid       = '0;
    cache_req_valid = 1'b0;
    cache_rsp_ready = 1'b0;
    update_en       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = grant_reject ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cache_req_valid = 1'b1;
        if (cache_req_ready) begin
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cache_rsp_ready = 1'b1;
        if (cache_rsp_valid) begin
          update_en  = cache_rsp_success;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid[cur_port] = 1'b1;
        if (rsp_ready[cur_port]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant    <= IDX_W'(NUM_PORTS - 1);
      cur_port      <= '0;
      cur_addr      <= '0;
      cur_data      <= '0;
      cur_mask      <= '0;
      cur_lock      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_success_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cur_port <= grant_idx;
            cur_addr <= grant_addr;
            cur_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            cur_mask <= req_mask[int'(grant_idx)*MASK_W +: MASK_W];
            cur_lock <= req_lock[grant_idx];
            if (grant_reject) begin
              rsp_data_q    <= '0;
              rsp_success_q <= 1'b0;
            end
          end
        end
        WAIT_RSP: begin
          if (cache_rsp_valid) begin
            rsp_data_q    <= cache_rsp_data;
            rsp_success_q <= cache_rsp_success;
          end
        end
        RESP: begin
          if (rsp_ready[cur_port]) begin
            last_grant <= cur_port;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data       = rsp_data_q;
  assign rsp_success    = rsp_success_q;
  assign cache_req_addr = cur_addr;
  assign cache_req_data = cur_data;
  assign cache_req_mask = cur_mask;
  assign cache_req_port = PORT_W'(cur_port);

endmodule
